// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcode enum, FSM state enum and
// the mode selector for the iterative shift/multiply datapath.
package seq_alu_pkg;

  typedef enum logic [3:0] {
    OP_PASS = 4'd0,
    OP_CLR  = 4'd1,
    OP_INC  = 4'd2,
    OP_ADD  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SLL1 = 4'd5,
    OP_SRL1 = 4'd6,
    OP_MASK = 4'd7,
    OP_SHLN = 4'd8,
    OP_SHRN = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } seq_alu_state_t;

  typedef enum logic [1:0] {
    ITER_SHL = 2'd0,
    ITER_SHR = 2'd1,
    ITER_MUL = 2'd2
  } iter_mode_t;

endpackage

// File: rtl/seq_alu_iter.sv
// One-step-per-cycle datapath for multi-bit shifts and (optionally) the
// shift-add multiply. Owns its own iteration counter; the top FSM loads it
// and steps it. The multiply accumulator exists only when SEQ_ALU_MUL_EN
// is defined.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic [CW-1:0]    count,
  output logic [WIDTH-1:0] res_next,
  output logic             ov_next,
  output logic             last
);

  iter_mode_t       mode_q;
  logic [WIDTH-1:0] data_q;
  logic [CW-1:0]    cnt_q;
`ifdef SEQ_ALU_MUL_EN
  // data_q doubles as the low half of the product (multiplier shifts out).
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH:0]   psum;
`endif

  // Operand/counter registers: load on accept, advance one step per RUN cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= ITER_SHL;
      data_q  <= '0;
      cnt_q   <= '0;
`ifdef SEQ_ALU_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else if (load) begin
      mode_q  <= mode;
      data_q  <= (mode == ITER_MUL) ? rt : rs;
      cnt_q   <= count;
`ifdef SEQ_ALU_MUL_EN
      hi_q    <= '0;
      mcand_q <= rs;
`endif
    end else if (step && (cnt_q != '0)) begin
      data_q  <= res_next;
      cnt_q   <= cnt_q - CW'(1);
`ifdef SEQ_ALU_MUL_EN
      hi_q    <= hi_next;
`endif
    end
  end

  // Value the datapath takes after the current step, plus the flag it produces.
  always_comb begin
    res_next = data_q;
    ov_next  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    hi_next  = hi_q;
    psum     = '0;
`endif
    case (mode_q)
      ITER_SHL: begin
        res_next = {data_q[WIDTH-2:0], 1'b0};
        ov_next  = data_q[WIDTH-1];
      end
      ITER_SHR: begin
        res_next = {1'b0, data_q[WIDTH-1:1]};
        ov_next  = data_q[0];
      end
`ifdef SEQ_ALU_MUL_EN
      ITER_MUL: begin
        psum     = {1'b0, hi_q} + (data_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        hi_next  = psum[WIDTH:1];
        res_next = {psum[0], data_q[WIDTH-1:1]};
        ov_next  = |psum[WIDTH:1];
      end
`endif
      default: ;
    endcase
  end

  // Final step: this is the edge on which the count reaches zero.
  always_comb begin
    last = (cnt_q == CW'(1));
  end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU top: IDLE/RUN/DONE FSM, single-cycle ALU, and the
// iterative shift/multiply sub-module. Optional feature macro:
// SEQ_ALU_MUL_EN enables the shift-add multiply for OP_MUL; without it
// OP_MUL behaves like any unused opcode.
//
// Request handshake: start_i is the valid; the block is ready whenever
// busy_o is low (IDLE or DONE). A request is taken on a rising clk edge
// where start_i=1 and busy_o=0; start_i while busy_o=1 is dropped.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start_i,
  input  alu_op_t        op_i,
  input  logic [WIDTH-1:0] rs_i,
  input  logic [WIDTH-1:0] rt_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [WIDTH-1:0] result_o,
  output logic           ov_o,
  output logic           bnz_o,
  output seq_alu_state_t state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  seq_alu_state_t   state_q, state_d;
  logic             accept;
  logic             is_multi;
  iter_mode_t       iter_mode;
  logic [CW-1:0]    iter_count;
  logic [CW-1:0]    amt;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;
  logic [WIDTH-1:0] iter_res;
  logic             iter_ov;
  logic             iter_last;

  assign amt    = CW'(rt_i[SHW-1:0]);
  assign accept = start_i && (state_q != ST_RUN);

  // Single-cycle results and the decision whether the op needs RUN.
  always_comb begin
    alu_res    = '0;
    alu_ov     = ov_o;
    is_multi   = 1'b0;
    iter_mode  = ITER_SHL;
    iter_count = amt;
    sum        = '0;
    case (op_i)
      OP_PASS: alu_res = rs_i;
      OP_CLR: begin
        alu_res = '0;
        alu_ov  = 1'b0;
      end
      OP_INC: begin
        sum     = {1'b0, rs_i} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_ov  = sum[WIDTH];
      end
      OP_ADD: begin
        sum     = {1'b0, rs_i} + {1'b0, rt_i} + {{WIDTH{1'b0}}, ov_o};
        alu_res = sum[WIDTH-1:0];
        alu_ov  = sum[WIDTH];
      end
      OP_SUB: begin
        // ov reports "no borrow": the inverted MSB of the WIDTH+1 result.
        sum     = {1'b0, rs_i} - {1'b0, rt_i} + {{WIDTH{1'b0}}, ov_o};
        alu_res = sum[WIDTH-1:0];
        alu_ov  = ~sum[WIDTH];
      end
      OP_SLL1: begin
        alu_res = {rs_i[WIDTH-2:0], ov_o};
        alu_ov  = rs_i[WIDTH-1];
      end
      OP_SRL1: begin
        alu_res = {ov_o, rs_i[WIDTH-1:1]};
        alu_ov  = rs_i[0];
      end
      OP_MASK: alu_res = rs_i & rt_i;
      OP_SHLN: begin
        alu_res   = rs_i;
        is_multi  = (amt != '0);
        iter_mode = ITER_SHL;
      end
      OP_SHRN: begin
        alu_res   = rs_i;
        is_multi  = (amt != '0);
        iter_mode = ITER_SHR;
      end
`ifdef SEQ_ALU_MUL_EN
      OP_MUL: begin
        is_multi   = 1'b1;
        iter_mode  = ITER_MUL;
        iter_count = CW'(WIDTH);
      end
`endif
      default: alu_res = '0;
    endcase
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (accept && is_multi),
    .step     (state_q == ST_RUN),
    .mode     (iter_mode),
    .rs       (rs_i),
    .rt       (rt_i),
    .count    (iter_count),
    .res_next (iter_res),
    .ov_next  (iter_ov),
    .last     (iter_last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: DONE is ready like IDLE, so back-to-back ops chain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = is_multi ? ST_RUN : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_RUN:  if (iter_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Result/flag register: written only on the edge that enters DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_o <= '0;
      ov_o     <= 1'b0;
    end else if (accept && !is_multi) begin
      result_o <= alu_res;
      ov_o     <= alu_ov;
    end else if ((state_q == ST_RUN) && iter_last) begin
      result_o <= iter_res;
      ov_o     <= iter_ov;
    end
  end

  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = (state_q == ST_DONE);
  assign bnz_o   = |result_o;
  assign state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=8). Expected values are hand
// computed; SEQ_ALU_MUL_EN selects the MUL expectations.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int WIDTH = 8;

  logic             clk;
  logic             reset;
  logic             start_i;
  alu_op_t          op_i;
  logic [WIDTH-1:0] rs_i;
  logic [WIDTH-1:0] rt_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             ov_o;
  logic             bnz_o;
  seq_alu_state_t   state_o;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH:0] exp_q[$];

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_i),
    .op_i     (op_i),
    .rs_i     (rs_i),
    .rt_i     (rt_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .ov_o     (ov_o),
    .bnz_o    (bnz_o),
    .state_o  (state_o)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Present a request; returns #1 after the edge that samples it.
  task automatic issue(input alu_op_t op, input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] rt);
    start_i = 1'b1;
    op_i    = op;
    rs_i    = rs;
    rt_i    = rt;
    @(posedge clk);
    #1;
    start_i = 1'b0;
  endtask

  // Issue and count RUN cycles until busy drops (bounded).
  task automatic run_op(input alu_op_t op, input logic [WIDTH-1:0] rs, input logic [WIDTH-1:0] rt,
                        input bit pulse_mid, output int cycles);
    int guard;
    issue(op, rs, rt);
    cycles = 0;
    guard  = 0;
    while (busy_o && guard < 50) begin
      cycles++;
      if (pulse_mid && cycles == 2) begin
        start_i = 1'b1;
        op_i    = OP_PASS;
        rs_i    = 8'hFF;
        rt_i    = 8'h00;
      end
      @(posedge clk);
      #1;
      start_i = 1'b0;
      guard++;
    end
  endtask

  // Back-to-back single-cycle vectors: op, rs, rt, expected {ov,result}
  alu_op_t          t_op[10];
  logic [WIDTH-1:0] t_rs[10];
  logic [WIDTH-1:0] t_rt[10];
  logic [WIDTH:0]   t_exp[10];

  initial begin
    int cyc;
    bit saw_done;
    logic [WIDTH:0] e;

    t_op[0] = OP_SUB;  t_rs[0] = 8'h05; t_rt[0] = 8'h03; t_exp[0] = {1'b1, 8'h02};
    t_op[1] = OP_PASS; t_rs[1] = 8'hA5; t_rt[1] = 8'h00; t_exp[1] = {1'b1, 8'hA5};
    t_op[2] = alu_op_t'(4'hE);
                       t_rs[2] = 8'h55; t_rt[2] = 8'hFF; t_exp[2] = {1'b1, 8'h00};
    t_op[3] = OP_SLL1; t_rs[3] = 8'h80; t_rt[3] = 8'h00; t_exp[3] = {1'b1, 8'h01};
    t_op[4] = OP_SRL1; t_rs[4] = 8'h02; t_rt[4] = 8'h00; t_exp[4] = {1'b0, 8'h81};
    t_op[5] = OP_MASK; t_rs[5] = 8'hF0; t_rt[5] = 8'h3C; t_exp[5] = {1'b0, 8'h30};
    t_op[6] = OP_INC;  t_rs[6] = 8'hFF; t_rt[6] = 8'h00; t_exp[6] = {1'b1, 8'h00};
    t_op[7] = OP_CLR;  t_rs[7] = 8'h77; t_rt[7] = 8'h00; t_exp[7] = {1'b0, 8'h00};
    t_op[8] = OP_SUB;  t_rs[8] = 8'h03; t_rt[8] = 8'h05; t_exp[8] = {1'b0, 8'hFE};
    t_op[9] = OP_ADD;  t_rs[9] = 8'h01; t_rt[9] = 8'h01; t_exp[9] = {1'b0, 8'h02};

    reset   = 1'b0;
    start_i = 1'b0;
    op_i    = OP_PASS;
    rs_i    = '0;
    rt_i    = '0;

    // Asynchronous reset takes effect before any clock edge
    #2 reset = 1'b1;
    #1;
    check("rst_result", result_o, 0);
    check("rst_ov", ov_o, 0);
    check("rst_done", done_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_bnz", bnz_o, 0);
    check("rst_state", state_o, ST_IDLE);

    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First edge after release accepts the request; done one cycle later
    issue(OP_ADD, 8'hFF, 8'h01);
    check("add1_done", done_o, 1);
    check("add1_result", result_o, 8'h00);
    check("add1_ov", ov_o, 1);
    check("add1_bnz", bnz_o, 0);

    // Back-to-back ADD using the carry just produced
    issue(OP_ADD, 8'h10, 8'h20);
    check("add2_done", done_o, 1);
    check("add2_result", result_o, 8'h31);
    check("add2_ov", ov_o, 0);
    check("add2_bnz", bnz_o, 1);

    // Table vectors, issued back to back
    for (int i = 0; i < 10; i++) exp_q.push_back(t_exp[i]);
    for (int i = 0; i < 10; i++) begin
      issue(t_op[i], t_rs[i], t_rt[i]);
      e = exp_q.pop_front();
      check($sformatf("vec%0d_done", i), done_o, 1);
      check($sformatf("vec%0d_result", i), result_o, e[WIDTH-1:0]);
      check($sformatf("vec%0d_ov", i), ov_o, e[WIDTH]);
    end

    // Idle cycle: done drops, result held
    @(posedge clk);
    #1;
    check("idle_done", done_o, 0);
    check("idle_result", result_o, 8'h02);
    check("idle_busy", busy_o, 0);

    // SHLN by 3 with an ignored mid-run start
    run_op(OP_SHLN, 8'h81, 8'h03, 1'b1, cyc);
    check("shln_busy_cycles", cyc, 3);
    check("shln_done", done_o, 1);
    check("shln_result", result_o, 8'h08);
    check("shln_ov", ov_o, 0);
    @(posedge clk);
    #1;
    check("shln_after_done", done_o, 0);
    check("shln_after_result", result_o, 8'h08);

    // SHRN by 1: last bit shifted out is 1
    run_op(OP_SHRN, 8'h05, 8'h01, 1'b0, cyc);
    check("shrn1_busy_cycles", cyc, 1);
    check("shrn1_result", result_o, 8'h02);
    check("shrn1_ov", ov_o, 1);

    // SHRN by 0: single cycle, rs passes, ov untouched
    run_op(OP_SHRN, 8'h81, 8'h00, 1'b0, cyc);
    check("shrn0_busy_cycles", cyc, 0);
    check("shrn0_done", done_o, 1);
    check("shrn0_result", result_o, 8'h81);
    check("shrn0_ov", ov_o, 1);

    // MUL 0x10 * 0x11 = 0x0110
    run_op(OP_MUL, 8'h10, 8'h11, 1'b0, cyc);
    check("mul_done", done_o, 1);
`ifdef SEQ_ALU_MUL_EN
    check("mul_busy_cycles", cyc, 8);
    check("mul_result", result_o, 8'h10);
    check("mul_ov", ov_o, 1);
`else
    check("mul_busy_cycles", cyc, 0);
    check("mul_result", result_o, 8'h00);
    check("mul_ov", ov_o, 1);
`endif

    // Non-zero result before the abort test
    issue(OP_PASS, 8'hA5, 8'h00);
    check("pre_rst_result", result_o, 8'hA5);

    // Reset during the 4th MUL cycle
    issue(OP_MUL, 8'h10, 8'h11);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
`ifdef SEQ_ALU_MUL_EN
    check("mul4_busy", busy_o, 1);
`else
    check("mul4_busy", busy_o, 0);
`endif
    #2 reset = 1'b1;
    #1;
    check("abort_result", result_o, 0);
    check("abort_ov", ov_o, 0);
    check("abort_done", done_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_bnz", bnz_o, 0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done_o || busy_o) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    check("abort_result_held", result_o, 0);

    // Normal operation after the abort
    issue(OP_PASS, 8'h3C, 8'h00);
    check("post_done", done_o, 1);
    check("post_result", result_o, 8'h3C);
    check("post_bnz", bnz_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits (legal 4..32).
REQ-002 Parameter SHW, default $clog2(WIDTH), width of the shift-amount field taken from rt_i[SHW-1:0].
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start_i  input  1  request; op_i/rs_i/rt_i are sampled when start_i=1 and the block is not busy.
REQ-006 op_i  input  4  operation, type alu_op_t.
REQ-007 rs_i  input  WIDTH  operand s.
REQ-008 rt_i  input  WIDTH  operand t, or the shift amount.
REQ-009 busy_o  output  1  high while a multi-cycle operation runs.
REQ-010 done_o  output  1  one-cycle pulse when result_o/ov_o are updated.
REQ-011 result_o  output  WIDTH  registered result, held until the next done_o.
REQ-012 ov_o  output  1  registered carry/shift-out flag, also the carry-in of the next operation.
REQ-013 bnz_o  output  1  combinational result_o != 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE + accepted start, single-cycle op -> DONE.
- IDLE + accepted start, multi-cycle op -> RUN.
- RUN -> DONE when the iteration count reaches 0.
- DONE -> IDLE, or straight to DONE/RUN if start_i=1 in that cycle.
REQ-015 A start_i accepted at edge N SHALL give done_o=1 in cycle N+1 for single-cycle ops: PASS, CLR, INC, ADD, SUB, SLL1, SRL1, MASK.
REQ-016 Single-cycle op results SHALL be:
- PASS = rs.
- CLR = 0, with ov cleared.
- INC: {ov,result} = rs+1.
- ADD: {ov,result} = rs+rt+ov.
- SUB: {ov,result} = rs-rt+ov, with ov = borrow-inverted carry of the WIDTH+1 result.
- SLL1: result = {rs[WIDTH-2:0],ov}, ov = rs[WIDTH-1].
- SRL1: result = {ov,rs[WIDTH-1:1]}, ov = rs[0].
- MASK: result = rs & rt, ov unchanged.
REQ-017 SHLN/SHRN SHALL shift one bit per cycle for rt_i[SHW-1:0] cycles, feeding 0 in and leaving ov = the last bit shifted out.
REQ-018 SHLN/SHRN with a shift amount of 0 SHALL complete in 1 cycle, with result = rs and ov unchanged.
REQ-019 busy_o SHALL be 1 exactly in RUN.
REQ-020 start_i SHALL be ignored while busy_o=1, with no effect on state, operands or outputs.
REQ-021 start_i asserted in the DONE cycle SHALL be accepted, giving back-to-back throughput of 1 op/cycle for single-cycle ops.
REQ-022 result_o and ov_o SHALL change only on the edge that raises done_o.
REQ-023 An unused op_i encoding SHALL complete in 1 cycle, with result = 0 and ov unchanged.
REQ-024 All additions SHALL be computed at WIDTH+1 bits, with the MSB going to ov.

Reset
REQ-025 reset=1 SHALL immediately force:
- state = IDLE.
- result_o = 0, ov_o = 0.
- done_o = 0, busy_o = 0.
- bnz_o = 0.
- iteration counter = 0.
REQ-026 reset asserted mid-RUN SHALL abort the operation, with no done_o pulse after release.
REQ-027 The first start_i SHALL be accepted on the first clk edge with reset=0.

Configuration
REQ-028 With macro SEQ_ALU_MUL_EN defined, op MUL SHALL do a shift-add multiply.
- It takes WIDTH cycles in RUN, then done_o.
- result = the low WIDTH bits of rs*rt.
- ov = OR of the high WIDTH bits.
REQ-029 Without SEQ_ALU_MUL_EN, MUL SHALL behave as an unused encoding (REQ-023) and no multiplier accumulator SHALL be synthesized.

Structure
REQ-030 Package definitions SHALL hold:
- the enum alu_op_t (4-bit).
- the FSM state enum seq_alu_state_t.
REQ-031 The one-bit-per-cycle shift/multiply datapath SHALL be a sub-module, seq_alu_iter, with its own counter, controlled by the top FSM.

Verification
REQ-032 WIDTH=8: reset, ADD rs=0xFF rt=0x01 with ov=0 -> done at N+1, result=0x00, ov=1, bnz_o=0.
REQ-033 ADD rs=0x10 rt=0x20 immediately after REQ-032 (ov=1) -> result=0x31, ov=0, bnz_o=1.
REQ-034 SHLN rs=0x81 rt=3 -> busy_o high for 3 cycles, start_i pulse mid-run ignored, result=0x08, ov=0.
REQ-035 SHRN rs=0x81 rt=0 -> 1-cycle completion, result=0x81, ov unchanged.
REQ-036 With SEQ_ALU_MUL_EN: MUL rs=0x10 rt=0x11 -> done after 8 RUN cycles, result=0x10, ov=1.
REQ-037 Without SEQ_ALU_MUL_EN: the same MUL -> done at N+1, result=0x00.
REQ-038 reset asserted during the 4th MUL cycle -> all outputs 0, no done_o pulse after release.
